// File: rtl/decoder_pkg.sv
// Shared types and constants for the sequenced 3-to-8 decoder.
// Widths and the default hold length live here so all files agree.
package decoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int CODE_W       = 3;
  localparam int OUT_W        = 8;
  localparam int HOLD_DEFAULT = 4;

endpackage

// File: rtl/decoder3to8_seq_if.sv
// Code-in / one-hot-out bundle for decoder3to8_seq.
// master drives codes, slave is the decoder.
interface decoder3to8_seq_if;
  import decoder_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;
  logic              in_en;
  logic [OUT_W-1:0]  out_onehot;
  logic              out_valid;
  logic              done;

  modport master (
    output in_valid,
    output in_code,
    output in_en,
    input  in_ready,
    input  out_onehot,
    input  out_valid,
    input  done
  );

  modport slave (
    input  in_valid,
    input  in_code,
    input  in_en,
    output in_ready,
    output out_onehot,
    output out_valid,
    output done
  );

endinterface

// File: rtl/dec3to8_core.sv
// Combinational 3-to-8 decoder with enable.
// A cleared enable yields an all-zero word.
module dec3to8_core
  import decoder_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  input  logic              i_en,
  output logic [OUT_W-1:0]  o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_code] = 1'b1;
  end

endmodule

// File: rtl/decoder3to8_seq.sv
// Holds each decoded one-hot word for HOLD cycles, with a
// one-entry pending buffer so back-to-back codes run gap-free.
module decoder3to8_seq #(
  parameter int HOLD = decoder_pkg::HOLD_DEFAULT
) (
  input logic               clk,
  input logic               rst_n,
  decoder3to8_seq_if.slave  bus
);
  import decoder_pkg::*;

  localparam logic [7:0] HOLD_M1   = 8'(HOLD - 1);
  localparam logic       HOLD_LAST = (HOLD == 1);

  state_t            r_state;
  logic [7:0]        r_cnt;
  logic              r_pend_full;
  logic [CODE_W-1:0] r_pend_code;
  logic              r_pend_en;
  logic [OUT_W-1:0]  r_onehot;
  logic              r_valid;
  logic              r_done;

  logic              w_ready;
  logic              w_acc;
  logic              w_last;
  logic [CODE_W-1:0] w_sel_code;
  logic              w_sel_en;
  logic [OUT_W-1:0]  w_word;

  assign w_ready = (r_state == IDLE) | ~r_pend_full;
  assign w_acc   = bus.in_valid & w_ready;
  assign w_last  = (r_cnt == 8'd0);

  // One decoder serves both paths: a full buffer always loads first.
  assign w_sel_code = r_pend_full ? r_pend_code : bus.in_code;
  assign w_sel_en   = r_pend_full ? r_pend_en   : bus.in_en;

  dec3to8_core u_core (
    .i_code   (w_sel_code),
    .i_en     (w_sel_en),
    .o_onehot (w_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
      r_pend_full <= 1'b0;
      r_pend_code <= '0;
      r_pend_en   <= 1'b0;
      r_onehot    <= '0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_onehot <= w_word;
            r_valid  <= 1'b1;
            r_cnt    <= HOLD_M1;
            r_done   <= HOLD_LAST;
            r_state  <= decoder_pkg::HOLD;
          end
        end
        decoder_pkg::HOLD: begin
          if (!w_last) begin
            r_cnt  <= r_cnt - 8'd1;
            r_done <= (r_cnt == 8'd1);
            if (w_acc) begin
              r_pend_full <= 1'b1;
              r_pend_code <= bus.in_code;
              r_pend_en   <= bus.in_en;
            end
          end else if (r_pend_full | w_acc) begin
            r_onehot    <= w_word;
            r_cnt       <= HOLD_M1;
            r_done      <= HOLD_LAST;
            r_pend_full <= 1'b0;
          end else begin
            r_onehot <= '0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.out_onehot = r_onehot;
  assign bus.out_valid  = r_valid;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_decoder3to8_seq.sv
// Scoreboard bench for decoder3to8_seq at HOLD=4 and HOLD=1.
// Stimulus pushes expected words; monitors pop on out_valid.
module tb_decoder3to8_seq;

  localparam int H0 = 4;
  localparam int H1 = 1;

  typedef struct packed {
    logic [7:0] w;
    logic       d;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n0;
  logic rst_n1;
  logic mon_en = 1'b0;

  int nvec = 0;
  int nerr = 0;
  int vcnt0 = 0;
  int dcnt0 = 0;
  int vcnt1 = 0;
  int dcnt1 = 0;

  exp_t q0[$];
  exp_t q1[$];

  decoder3to8_seq_if if0 ();
  decoder3to8_seq_if if1 ();

  decoder3to8_seq #(.HOLD(H0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n0),
    .bus   (if0)
  );

  decoder3to8_seq #(.HOLD(H1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n1),
    .bus   (if1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (if0.out_valid) begin
        vcnt0++;
        if (q0.size() == 0) begin
          chk("m0_unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = q0.pop_front();
          chk("m0_word", if0.out_onehot, e.w);
          chk("m0_done", if0.done, e.d);
        end
      end else begin
        chk("m0_idle_word", if0.out_onehot, 0);
        chk("m0_idle_done", if0.done, 0);
      end
      if (if0.done) dcnt0++;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (if1.out_valid) begin
        vcnt1++;
        if (q1.size() == 0) begin
          chk("m1_unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = q1.pop_front();
          chk("m1_word", if1.out_onehot, e.w);
          chk("m1_done", if1.done, e.d);
        end
      end else begin
        chk("m1_idle_word", if1.out_onehot, 0);
        chk("m1_idle_done", if1.done, 0);
      end
      if (if1.done) dcnt1++;
    end
  end

  // Offer one code; n expected entries are queued on acceptance,
  // the last carrying done when lastd is set.
  task automatic send(input int sel, input logic [2:0] code,
                      input logic en, input logic [7:0] w,
                      input int n, input bit lastd,
                      output int stalls);
    logic rdy;
    exp_t e;
    stalls = 0;
    if (sel == 0) begin
      if0.in_valid = 1'b1;
      if0.in_code  = code;
      if0.in_en    = en;
    end else begin
      if1.in_valid = 1'b1;
      if1.in_code  = code;
      if1.in_en    = en;
    end
    forever begin
      @(negedge clk);
      rdy = (sel == 0) ? if0.in_ready : if1.in_ready;
      @(posedge clk);
      if (rdy) break;
      stalls++;
      if (stalls > 50) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    for (int i = 0; i < n; i++) begin
      e.w = w;
      e.d = lastd && (i == n - 1);
      if (sel == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    #1;
    if (sel == 0) if0.in_valid = 1'b0;
    else if1.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int sel);
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      if (sel == 0 && !if0.out_valid) break;
      if (sel == 1 && !if1.out_valid) break;
      k++;
      if (k > 100) begin
        chk("idle_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [2:0] codes27 [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 3};
  logic       ens27   [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
  logic [7:0] words27 [9] = '{8'h01, 8'h02, 8'h04, 8'h08,
                              8'h10, 8'h20, 8'h40, 8'h80,
                              8'h00};

  initial begin
    int st;
    int v0;
    int d1;
    if0.in_valid = 1'b0;
    if0.in_code  = '0;
    if0.in_en    = 1'b0;
    if1.in_valid = 1'b0;
    if1.in_code  = '0;
    if1.in_en    = 1'b0;
    rst_n0 = 1'b0;
    rst_n1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n0 = 1'b1;
    rst_n1 = 1'b1;
    mon_en = 1'b1;

    @(negedge clk);
    chk("rst_word0", if0.out_onehot, 0);
    chk("rst_valid0", if0.out_valid, 0);
    chk("rst_done0", if0.done, 0);
    chk("rst_ready0", if0.in_ready, 1);
    chk("rst_ready1", if1.in_ready, 1);
    chk("rst_valid1", if1.out_valid, 0);
    @(posedge clk);
    #1;

    // Single code 5, four-cycle hold
    send(0, 3'd5, 1'b1, 8'h20, H0, 1'b1, st);
    chk("c5_stalls", st, 0);
    wait_idle(0);
    chk("c5_ready_after", if0.in_ready, 1);
    chk("c5_done_count", dcnt0, 1);

    // Sweep all codes, then a disabled code
    for (int i = 0; i < 9; i++)
      send(0, codes27[i], ens27[i], words27[i], H0, 1'b1, st);
    wait_idle(0);
    chk("sweep_q_empty", q0.size(), 0);
    chk("sweep_done_count", dcnt0, 10);

    // Back-to-back 2,6,1 through the pending buffer
    v0 = vcnt0;
    send(0, 3'd2, 1'b1, 8'h04, H0, 1'b1, st);
    chk("b2b_c2_stalls", st, 0);
    send(0, 3'd6, 1'b1, 8'h40, H0, 1'b1, st);
    chk("b2b_c6_stalls", st, 0);
    send(0, 3'd1, 1'b1, 8'h02, H0, 1'b1, st);
    chk("b2b_c1_stalls", st, 3);
    wait_idle(0);
    chk("b2b_valid_cycles", vcnt0 - v0, 12);
    chk("b2b_q_empty", q0.size(), 0);

    // HOLD=1 streaming
    d1 = dcnt1;
    send(1, 3'd7, 1'b1, 8'h80, H1, 1'b1, st);
    chk("h1_c7_stalls", st, 0);
    send(1, 3'd0, 1'b1, 8'h01, H1, 1'b1, st);
    chk("h1_c0_stalls", st, 0);
    send(1, 3'd4, 1'b1, 8'h10, H1, 1'b1, st);
    chk("h1_c4_stalls", st, 0);
    wait_idle(1);
    chk("h1_done_count", dcnt1 - d1, 3);
    chk("h1_q_empty", q1.size(), 0);

    // Reset during the second hold cycle of code 6, code 1 pending
    send(0, 3'd6, 1'b1, 8'h40, 2, 1'b0, st);
    send(0, 3'd1, 1'b1, 8'h02, 0, 1'b0, st);
    chk("rst_c1_stalls", st, 0);
    rst_n0 = 1'b0;
    @(posedge clk);
    #1;
    rst_n0 = 1'b1;
    @(negedge clk);
    chk("rsth_word", if0.out_onehot, 0);
    chk("rsth_valid", if0.out_valid, 0);
    chk("rsth_done", if0.done, 0);
    chk("rsth_ready", if0.in_ready, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("rsth_q_empty", q0.size(), 0);

    @(negedge clk);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
